// File: rtl/pwm_capture.sv
// pwm_capture: decodes one RC-style PWM input into a pulse width in us and a 0..1000 position.
// Latency: valid/error strobe lands 3 clk edges after pwm_in falls (2 sync stages + output register).
// Backpressure: none; valid/error are single-cycle strobes and outputs hold between strobes.
//
// Ports:
//   clk      system clock
//   reset    synchronous active-high reset
//   pwm_in   asynchronous PWM input from the header pin
//   width_us last accepted pulse width in us
//   position clamp(width_us,1000,2000)-1000
//   valid    one-cycle strobe, width_us/position just loaded
//   error    one-cycle strobe, pulse rejected (too short or too long)
//   lost     level, no rising edge for TIMEOUT_US
module pwm_capture #(
    parameter int CLKS_PER_US = 100,
    parameter int MIN_US      = 800,
    parameter int MAX_US      = 2200,
    parameter int TIMEOUT_US  = 25000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pwm_in,
    output logic [15:0] width_us,
    output logic [9:0]  position,
    output logic        valid,
    output logic        error,
    output logic        lost
);

    localparam int PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           sync1;
    logic           pwm_s;
    logic           pwm_d;
    logic [1:0]     primed;
    logic           rise;
    logic           fall;
    logic           us_tick;
    logic [PW-1:0]  presc;
    logic [15:0]    width_cnt;
    logic [15:0]    width_inc;
    logic [15:0]    to_cnt;
    logic [15:0]    to_inc;
    logic [9:0]     pos_nxt;
    logic           accept;
    logic           reject;

    assign rise    = pwm_s & ~pwm_d;
    assign fall    = ~pwm_s & pwm_d;
    assign us_tick = (presc == PW'(CLKS_PER_US - 1));

    // Saturating increments; width_inc already includes a tick that lands in
    // the fall cycle, so the captured width is floor(high_cycles / CLKS_PER_US).
    assign width_inc = (us_tick && (width_cnt != 16'hFFFF)) ? width_cnt + 16'd1 : width_cnt;
    assign to_inc    = (us_tick && (to_cnt != 16'hFFFF)) ? to_cnt + 16'd1 : to_cnt;

    always_comb begin
        pos_nxt = 10'd0;
        if (width_inc >= 16'd2000) begin
            pos_nxt = 10'd1000;
        end else if (width_inc > 16'd1000) begin
            pos_nxt = 10'(width_inc - 16'd1000);
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        reject    = 1'b0;
        case (state)
            ARM: begin
                // The sync flops come out of reset as zeros; primed keeps us in
                // ARM until pwm_s reflects a real sample of the pin, so a pulse
                // already high at reset release is never measured.
                if (primed[1] && !pwm_s) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (rise) begin
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                // Overflow is checked first so that overflow coincident with
                // fall counts as a rejected pulse.
                if (width_inc > 16'(MAX_US)) begin
                    reject    = 1'b1;
                    state_nxt = ARM;
                end else if (fall) begin
                    if (width_inc < 16'(MIN_US)) begin
                        reject = 1'b1;
                    end else begin
                        accept = 1'b1;
                    end
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = ARM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= 1'b0;
            pwm_s     <= 1'b0;
            pwm_d     <= 1'b0;
            primed    <= 2'b00;
            presc     <= '0;
            width_cnt <= 16'd0;
            to_cnt    <= 16'd0;
            state     <= ARM;
            width_us  <= 16'd0;
            position  <= 10'd0;
            valid     <= 1'b0;
            error     <= 1'b0;
            lost      <= 1'b0;
        end else begin
            sync1  <= pwm_in;
            pwm_s  <= sync1;
            pwm_d  <= pwm_s;
            primed <= {primed[0], 1'b1};

            // Prescaler restarts on rise so every pulse sees whole-us ticks
            // measured from its own leading edge.
            if (rise || us_tick) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end

            to_cnt <= rise ? 16'd0 : to_inc;
            state  <= state_nxt;

            if (state == IDLE && rise) begin
                width_cnt <= 16'd0;
            end else if (state == HIGH) begin
                width_cnt <= width_inc;
            end

            valid <= accept;
            error <= reject;
            if (accept) begin
                width_us <= width_inc;
                position <= pos_nxt;
            end

            // A fresh measurement clears lost; a bare rise does not.
            if (accept) begin
                lost <= 1'b0;
            end else if (!rise && (to_inc >= 16'(TIMEOUT_US))) begin
                lost <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture with a scaled-down clock/us ratio so whole pulse
// trains fit a short run. Stimulus pushes expected strobes into a queue;
// a negedge monitor pops and compares whenever valid or error fires.
module tb_pwm_capture;

    localparam int C    = 2;
    localparam int MINU = 800;
    localparam int MAXU = 2200;
    localparam int TOU  = 4000;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        pwm_in = 1'b0;
    logic [15:0] width_us;
    logic [9:0]  position;
    logic        valid;
    logic        error;
    logic        lost;

    pwm_capture #(
        .CLKS_PER_US(C),
        .MIN_US     (MINU),
        .MAX_US     (MAXU),
        .TIMEOUT_US (TOU)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .pwm_in  (pwm_in),
        .width_us(width_us),
        .position(position),
        .valid   (valid),
        .error   (error),
        .lost    (lost)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_err;
        int w;
        int p;
        int at;
    } exp_t;

    exp_t q[$];
    int   errors    = 0;
    int   checks    = 0;
    int   last_rise = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset === 1'b0 && (valid === 1'b1 || error === 1'b1)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: valid=%0b error=%0b width_us=%0d at cycle %0d, expected no strobe",
                         valid, error, width_us, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("strobe_is_error", {31'd0, error}, {31'd0, e.is_err});
                chk("strobe_cycle", cyc, e.at);
                chk("width_us", {16'd0, width_us}, e.w);
                chk("position", {22'd0, position}, e.p);
                if (valid === 1'b1) chk("lost_clear_with_valid", {31'd0, lost}, 32'd0);
            end
        end
    end

    task automatic reset_pulse(input int n);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_width_us", {16'd0, width_us}, 32'd0);
        chk("rst_position", {22'd0, position}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_lost", {31'd0, lost}, 32'd0);
        repeat (n - 1) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // kind: 0 accepted, 1 rejected at fall (short), 2 rejected by overflow
    task automatic pulse(input int hi, input int lo, input int kind,
                         input int w, input int p, input bit chk_lost);
        exp_t e;
        int   n;
        @(posedge clk);
        #1 pwm_in = 1'b1;
        n = cyc;
        last_rise = n;
        if (kind == 2) begin
            e.is_err = 1'b1; e.w = w; e.p = p; e.at = n + 3 + (MAXU + 1) * C;
            q.push_back(e);
        end
        repeat (hi * C) @(posedge clk);
        #1 pwm_in = 1'b0;
        if (kind != 2) begin
            e.is_err = (kind == 1); e.w = w; e.p = p; e.at = cyc + 3;
            q.push_back(e);
        end
        if (chk_lost) begin
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk("lost_held_after_rise", {31'd0, lost}, 32'd1);
            repeat (lo * C - 2) @(posedge clk);
        end else begin
            repeat (lo * C) @(posedge clk);
        end
    endtask

    initial begin
        int target;
        reset_pulse(4);
        repeat (10) @(posedge clk);

        // Nominal, clamps, rejections (outputs hold on error)
        pulse(1500, 100, 0, 1500, 500, 1'b0);
        pulse(900,  100, 0, 900,  0,    1'b0);
        pulse(2100, 100, 0, 2100, 1000, 1'b0);
        pulse(500,  100, 1, 2100, 1000, 1'b0);
        pulse(2500, 100, 2, 2100, 1000, 1'b0);
        pulse(1200, 100, 0, 1200, 200,  1'b0);

        // Reset released while pwm_in already high: partial pulse ignored
        @(posedge clk);
        #1 pwm_in = 1'b1;
        repeat (690 * C) @(posedge clk);
        reset_pulse(10 * C);
        repeat (800 * C) @(posedge clk);
        #1 pwm_in = 1'b0;
        repeat (100 * C) @(posedge clk);
        pulse(1500, 100, 0, 1500, 500, 1'b0);

        // Loss of signal: lost rises exactly TOU us after the last rise
        pulse(1500, 0, 0, 1500, 500, 1'b0);
        target = last_rise + 3 + TOU * C - 1;
        repeat (target - cyc) @(posedge clk);
        @(negedge clk);
        chk("lost_before_timeout", {31'd0, lost}, 32'd0);
        @(negedge clk);
        chk("lost_at_timeout", {31'd0, lost}, 32'd1);
        chk("width_hold_lost", {16'd0, width_us}, 32'd1500);
        chk("position_hold_lost", {22'd0, position}, 32'd500);
        repeat (50) @(posedge clk);
        pulse(1600, 100, 0, 1600, 600, 1'b1);

        // Reset in the middle of a high phase: no strobe for that pulse
        @(posedge clk);
        #1 pwm_in = 1'b1;
        repeat (600 * C) @(posedge clk);
        reset_pulse(4);
        repeat (900 * C) @(posedge clk);
        #1 pwm_in = 1'b0;
        repeat (100 * C) @(posedge clk);
        pulse(1500, 100, 0, 1500, 500, 1'b0);

        repeat (20) @(posedge clk);
        chk("pending_expected_strobes", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
